instr_mem_responder: RTL and testbench

- Multi-cycle instruction-memory responder: the memory side of the fetch interface.
- Accepts one fetch request at a time on a valid/ready handshake, inserts `LATENCY` wait states, then returns the addressed 16-bit word on a held response handshake.
- A program-load write port fills the memory; it is independent of the fetch path.
- Sits between the CPU fetch stage and the program store, replacing the zero-latency combinational fetch.

---
 rtl/instr_mem_responder_if.sv | 18 +
 rtl/instr_mem_responder.sv | 66 ++++++
 tb/tb_instr_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if: fetch request/response handshake bundle (master = CPU fetch stage, slave = responder)
interface instr_mem_responder_if;
  logic        ReqValid;
  logic [15:0] ReqAddr;
  logic        ReqReady;
  logic        RespValid;
  logic [15:0] RespData;
  logic        RespErr;
  logic        RespReady;
  modport master (
    output ReqValid, ReqAddr, RespReady,
    input  ReqReady, RespValid, RespData, RespErr
  );
  modport slave (
    input  ReqValid, ReqAddr, RespReady,
    output ReqReady, RespValid, RespData, RespErr
  );
endinterface

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: multi-cycle instruction memory; ports: clock, resetn (sync active-low), bus (fetch handshake), LoadEn/LoadAddr/LoadData (program load), Busy
module instr_mem_responder #(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  resetn,
  instr_mem_responder_if.slave  bus,
  input  logic                  LoadEn,
  input  logic [15:0]           LoadAddr,
  input  logic [15:0]           LoadData,
  output logic                  Busy
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t        state, state_n;
  logic [3:0]    cnt;
  logic [15:0]   cap_addr;
  logic [15:0]   mem [DEPTH];
  logic          load_ok, cap_ok;
  logic [IW-1:0] load_idx, cap_idx;
  logic [15:0]   rd_data;
  assign load_ok  = LoadEn && !LoadAddr[0] && 32'(LoadAddr[15:1]) < 32'(DEPTH);
  assign cap_ok   = !cap_addr[0] && 32'(cap_addr[15:1]) < 32'(DEPTH);
  assign load_idx = LoadAddr[IW:1];
  assign cap_idx  = cap_addr[IW:1];
  // write-first: a same-cycle load to the captured word wins over the stored value
  assign rd_data = !cap_ok ? HALT_WORD :
                   (load_ok && load_idx == cap_idx) ? LoadData : mem[cap_idx];
  assign bus.ReqReady  = state == S_IDLE;
  assign bus.RespValid = state == S_RESP;
  assign Busy          = state != S_IDLE;
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE ? (bus.ReqValid ? S_WAIT : S_IDLE) :
              state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT) :
              (bus.RespReady ? S_IDLE : S_RESP);
  end
  // memory has no reset so a loaded program survives resetn
  always_ff @(posedge clock) begin
    if (load_ok) mem[load_idx] <= LoadData;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      cap_addr     <= 16'h0000;
      bus.RespData <= 16'h0000;
      bus.RespErr  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.ReqValid) begin
        cap_addr <= bus.ReqAddr;
        cnt      <= 4'(LATENCY - 1);
      end
      if (state == S_WAIT) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          bus.RespData <= rd_data;
          bus.RespErr  <= !cap_ok;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed table-driven bench for instr_mem_responder
module tb_instr_mem_responder;
  logic        clock = 1'b0;
  logic        resetn;
  logic        LoadEn;
  logic [15:0] LoadAddr, LoadData;
  logic        Busy;
  int          total = 0, passed = 0;
  instr_mem_responder_if bus();
  instr_mem_responder #(.DEPTH(256), .LATENCY(2), .HALT_WORD(16'hFFFF)) dut (
    .clock(clock), .resetn(resetn), .bus(bus),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .Busy(Busy)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
  } vec_t;
  vec_t vecs[7];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic load(input logic [15:0] a, input logic [15:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask
  // issue one request with RespReady held high; checks latency, data, err and the return to idle
  task automatic fetch(input string nm, input logic [15:0] a, input logic [15:0] ed, input logic ee);
    int  n = 0;
    logic rdy_low = 1'b1;
    bus.ReqValid = 1'b1; bus.ReqAddr = a; bus.RespReady = 1'b1;
    tick();
    bus.ReqValid = 1'b0; bus.ReqAddr = 16'hAAA1;
    while (!bus.RespValid && n < 20) begin
      rdy_low &= !bus.ReqReady && Busy;
      tick();
      n++;
    end
    chk({nm, " latency"}, n, 2);
    chk({nm, " data"}, bus.RespData, ed);
    chk({nm, " err"}, bus.RespErr, ee);
    chk({nm, " busy_wait"}, rdy_low, 1);
    tick();
    chk({nm, " idle_after"}, {bus.RespValid, bus.ReqReady, Busy}, 3'b010);
  endtask
  initial begin
    int n;
    vecs[0] = '{16'h0002, 16'h5678, 1'b0};
    vecs[1] = '{16'h0000, 16'h1234, 1'b0};
    vecs[2] = '{16'h0004, 16'h9ABC, 1'b0};
    vecs[3] = '{16'h01FE, 16'h0BAD, 1'b0};
    vecs[4] = '{16'h0003, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0200, 16'hFFFF, 1'b1};
    vecs[6] = '{16'hFFFE, 16'hFFFF, 1'b1};
    resetn = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    bus.ReqValid = 1'b0; bus.ReqAddr = '0; bus.RespReady = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    chk("reset ReqReady", bus.ReqReady, 1);
    chk("reset RespValid", bus.RespValid, 0);
    chk("reset RespData", bus.RespData, 16'h0000);
    chk("reset RespErr", bus.RespErr, 0);
    chk("reset Busy", Busy, 0);
    load(16'h0000, 16'h1234);
    load(16'h0002, 16'h5678);
    load(16'h0004, 16'h9ABC);
    load(16'h01FE, 16'h0BAD);
    load(16'h0201, 16'h7777);
    load(16'h0003, 16'h5555);
    load(16'h0200, 16'h6666);
    for (int i = 0; i < 7; i++) fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err);
    // backpressure with a load to the same word while the response is held
    bus.ReqValid = 1'b1; bus.ReqAddr = 16'h0004; bus.RespReady = 1'b0;
    tick();
    bus.ReqValid = 1'b0;
    n = 0;
    while (!bus.RespValid && n < 20) begin tick(); n++; end
    chk("bp latency", n, 2);
    LoadEn = 1'b1; LoadAddr = 16'h0004; LoadData = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp hold%0d", i), {bus.RespValid, bus.RespData}, {1'b1, 16'h9ABC});
      tick();
      LoadEn = 1'b0;
    end
    bus.RespReady = 1'b1;
    tick();
    chk("bp release", bus.RespValid, 0);
    fetch("bp reload", 16'h0004, 16'hDEAD, 1'b0);
    // collision: load lands on the last WAIT cycle
    bus.ReqValid = 1'b1; bus.ReqAddr = 16'h0002;
    tick();
    bus.ReqValid = 1'b0;
    tick();
    LoadEn = 1'b1; LoadAddr = 16'h0002; LoadData = 16'hBEEF;
    tick();
    LoadEn = 1'b0;
    chk("collide", {bus.RespValid, bus.RespData}, {1'b1, 16'hBEEF});
    tick();
    // reset mid-WAIT, with a load riding on the reset edge
    bus.ReqValid = 1'b1; bus.ReqAddr = 16'h0002;
    tick();
    bus.ReqValid = 1'b0;
    resetn = 1'b0; LoadEn = 1'b1; LoadAddr = 16'h0006; LoadData = 16'h6666;
    tick();
    resetn = 1'b1; LoadEn = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      n += {31'd0, bus.RespValid | Busy};
      tick();
    end
    chk("abort no resp", n, 0);
    fetch("after reset", 16'h0000, 16'h1234, 1'b0);
    fetch("load in reset", 16'h0006, 16'h6666, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
